// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI transaction arbiter.
package spi_arb_pkg;

  localparam int unsigned NBITS_W  = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NREQ_MAX = 4;
  localparam int unsigned IDX_W    = $clog2(NREQ_MAX);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester granted last gets lowest priority.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] gnt_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic             found;

  // Winner search: first requester above the last grant, else wrap to the lowest index.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && req_i[i] && (IDX_W'(i) > last_q)) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Pointer update to the index of the accepted grant.
  always_comb begin
    last_d = last_q;
    if (adv_i) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (gnt_i[i]) last_d = IDX_W'(i);
      end
    end
  end

  // Pointer register; reset makes requester 0 the highest priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= IDX_W'(NREQ - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Multi-requester SPI mode-0 master with round-robin bus arbitration.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NREQ    = 2
) (
  input  logic                           axi_aclk,
  input  logic                           axi_areset,
  input  logic                           en,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0][DATA_W-1:0]    req_wdata,
  input  logic [NREQ-1:0][NBITS_W-1:0]   req_nbits,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           busy,
  output logic                           sck_o,
  output logic                           sck_t,
  output logic                           mosi_o,
  output logic                           mosi_t,
  output logic                           ss_o,
  output logic                           ss_t,
  input  logic                           miso_i
);

  localparam int unsigned       CNT_W    = 8;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NBITS_W-1:0]   bits_left_q;
  logic [DATA_W-1:0]    tx_q;
  logic [DATA_W-1:0]    rx_q;
  logic [NREQ-1:0]      owner_q;
  logic                 sck_q;
  logic                 mosi_q;
  logic                 ss_q;
  logic                 pin_t_q;
  logic                 busy_q;
  logic [NREQ-1:0]      rsp_valid_q;
  logic [DATA_W-1:0]    rsp_rdata_q;

  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      accept_vec;
  logic                 accept;
  logic [DATA_W-1:0]    sel_wdata;
  logic [NBITS_W-1:0]   sel_nbits;
  logic [DATA_W-1:0]    sel_aligned;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk_i (axi_aclk),
    .rst_i (axi_areset),
    .req_i (req_valid),
    .gnt_i (accept_vec),
    .adv_i (accept),
    .gnt_o (gnt)
  );

  // Grants are only offered while idle with bus ownership enabled.
  always_comb begin
    req_ready  = (state_q == IDLE && en) ? gnt : '0;
    accept_vec = req_valid & req_ready;
    accept     = |accept_vec;
  end

  // Winner payload mux; frame is left-aligned so the MSB of the frame sits at bit 31.
  always_comb begin
    sel_wdata = '0;
    sel_nbits = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        sel_wdata = req_wdata[i];
        sel_nbits = req_nbits[i];
      end
    end
    sel_aligned = sel_wdata << (NBITS_W'(DATA_W - 1) - sel_nbits);
  end

  // Transaction FSM with registered pin and response outputs.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_left_q <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      owner_q     <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
      pin_t_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          pin_t_q <= ~en;
          if (accept) begin
            state_q     <= SETUP;
            cnt_q       <= '0;
            bits_left_q <= sel_nbits;
            tx_q        <= sel_aligned;
            rx_q        <= '0;
            owner_q     <= accept_vec;
            mosi_q      <= sel_aligned[DATA_W-1];
            ss_q        <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= SHIFT_HI;
            cnt_q   <= '0;
            sck_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHIFT_HI: begin
          if (cnt_q == '0) rx_q <= {rx_q[DATA_W-2:0], miso_i};
          if (cnt_q == CNT_LAST) begin
            state_q <= SHIFT_LO;
            cnt_q   <= '0;
            sck_q   <= 1'b0;
            if (bits_left_q != '0) begin
              tx_q   <= tx_q << 1;
              mosi_q <= tx_q[DATA_W-2];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHIFT_LO: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bits_left_q == '0) begin
              state_q     <= GAP;
              ss_q        <= 1'b1;
              mosi_q      <= 1'b0;
              rsp_valid_q <= owner_q;
              rsp_rdata_q <= rx_q;
            end else begin
              state_q     <= SHIFT_HI;
              sck_q       <= 1'b1;
              bits_left_q <= bits_left_q - NBITS_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pin_t_q <= ~en;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;
  assign ss_o      = ss_q;
  assign sck_t     = pin_t_q;
  assign mosi_t    = pin_t_q;
  assign ss_t      = pin_t_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a per-cycle transaction-level model.
module tb_spi_txn_arbiter;

  localparam int unsigned CD = 2;
  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: CLK_DIV=2
  logic            en;
  logic [1:0]      req_valid, req_ready, rsp_valid;
  logic [1:0][31:0] req_wdata;
  logic [1:0][4:0] req_nbits;
  logic [31:0]     rsp_rdata;
  logic            busy, sck_o, sck_t, mosi_o, mosi_t, ss_o, ss_t, miso;
  bit              miso_mode;   // 0: loopback from mosi_o, 1: tied high
  assign miso = miso_mode ? 1'b1 : mosi_o;

  spi_txn_arbiter #(.CLK_DIV(CD), .NREQ(NR)) dut (
    .axi_aclk(clk), .axi_areset(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wdata(req_wdata), .req_nbits(req_nbits),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sck_o(sck_o), .sck_t(sck_t), .mosi_o(mosi_o), .mosi_t(mosi_t),
    .ss_o(ss_o), .ss_t(ss_t), .miso_i(miso)
  );

  // Instance B: CLK_DIV=1 for the minimum-frame case
  logic            b_en;
  logic [1:0]      b_req_valid, b_req_ready, b_rsp_valid;
  logic [1:0][31:0] b_req_wdata;
  logic [1:0][4:0] b_req_nbits;
  logic [31:0]     b_rsp_rdata;
  logic            b_busy, b_sck_o, b_sck_t, b_mosi_o, b_mosi_t, b_ss_o, b_ss_t, b_miso;

  spi_txn_arbiter #(.CLK_DIV(1), .NREQ(NR)) dut_b (
    .axi_aclk(clk), .axi_areset(rst), .en(b_en),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_wdata(b_req_wdata), .req_nbits(b_req_nbits),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .sck_o(b_sck_o), .sck_t(b_sck_t), .mosi_o(b_mosi_o), .mosi_t(b_mosi_t),
    .ss_o(b_ss_o), .ss_t(b_ss_t), .miso_i(b_miso)
  );

  typedef struct packed {
    logic        ss;
    logic        sck;
    logic        mosi;
    logic        busy;
    logic [1:0]  rsp;
    logic [31:0] rdata;
  } exp_t;

  exp_t   expq[$];
  int     gnt_log[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_on = 1'b0;
  logic   t_exp  = 1'b1;
  int     last_gnt = NR - 1;
  int     acc_cnt = 0;
  int     rsp_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_rsp = '0;
  int     pulses = 0, ss_run = 0, ss_len = 0;
  logic [31:0] mosi_cap = '0;
  logic   ss_prev = 1'b1, sck_prev = 1'b0;
  int     b_pulses = 0, b_run = 0, b_ss_len = 0, b_rsp_cnt = 0;
  logic [31:0] b_rdata = '0;
  logic [1:0]  b_rsp = '0;
  logic   b_ss_prev = 1'b1, b_sck_prev = 1'b0;

  exp_t   cur;
  bit     idle_now;
  int     win;
  logic [1:0] exp_rdy;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Round-robin rule: scan upward starting just after the last winner.
  function automatic int rr_pick(input logic [1:0] v, input int last);
    for (int k = 1; k <= int'(NR); k++) begin
      int c;
      c = (last + k) % int'(NR);
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Expected waveform for a whole transaction, one entry per cycle after accept.
  task automatic push_txn(input int idx, input logic [31:0] wd, input int n, input bit ones);
    exp_t e;
    logic [31:0] rd;
    rd = ones ? 32'hFFFF_FFFF : wd;
    if (n < 32) rd = rd & ((32'h1 << n) - 32'h1);
    e = '{ss: 1'b0, sck: 1'b0, mosi: wd[n-1], busy: 1'b1, rsp: 2'b00, rdata: 32'h0};
    repeat (CD) expq.push_back(e);
    for (int k = 0; k < n; k++) begin
      e.sck  = 1'b1;
      e.mosi = wd[n-1-k];
      repeat (CD) expq.push_back(e);
      e.sck = 1'b0;
      if (k != n - 1) e.mosi = wd[n-2-k];
      repeat (CD) expq.push_back(e);
    end
    e.ss = 1'b1; e.sck = 1'b0; e.mosi = 1'b0;
    e.rsp = 2'(1 << idx); e.rdata = rd;
    expq.push_back(e);
    e.rsp = 2'b00; e.rdata = 32'h0;
    repeat (CD - 1) expq.push_back(e);
  endtask

  // Per-cycle comparison against the model, plus waveform measurements.
  always @(negedge clk) begin
    if (mon_on) begin
      idle_now = (expq.size() == 0);
      if (!idle_now) cur = expq.pop_front();
      else cur = '{ss: 1'b1, sck: 1'b0, mosi: 1'b0, busy: 1'b0, rsp: 2'b00, rdata: 32'h0};
      exp_rdy = 2'b00;
      win = -1;
      if (idle_now && en) begin
        win = rr_pick(req_valid, last_gnt);
        if (win >= 0) exp_rdy[win] = 1'b1;
      end
      check1("ss_o", 32'(ss_o), 32'(cur.ss));
      check1("sck_o", 32'(sck_o), 32'(cur.sck));
      check1("mosi_o", 32'(mosi_o), 32'(cur.mosi));
      check1("busy", 32'(busy), 32'(cur.busy));
      check1("rsp_valid", 32'(rsp_valid), 32'(cur.rsp));
      check1("req_ready", 32'(req_ready), 32'(exp_rdy));
      check1("pin_t", 32'({sck_t, mosi_t, ss_t}), {29'h0, {3{t_exp}}});
      if (cur.rsp != 2'b00) check1("rsp_rdata", rsp_rdata, cur.rdata);
      if (rst) begin
        expq.delete();
        last_gnt = NR - 1;
        t_exp = 1'b1;
      end else begin
        if (win >= 0) begin
          push_txn(win, req_wdata[win], int'(req_nbits[win]) + 1, miso_mode);
          last_gnt = win;
          gnt_log.push_back(win);
          acc_cnt++;
        end
        t_exp = (expq.size() > 0) ? 1'b0 : ~en;
      end
      if (!ss_o) ss_run++;
      else if (!ss_prev) begin ss_len = ss_run; ss_run = 0; end
      if (sck_o && !sck_prev) begin pulses++; mosi_cap = {mosi_cap[30:0], mosi_o}; end
      if (rsp_valid != 2'b00) begin rsp_cnt++; last_rdata = rsp_rdata; last_rsp = rsp_valid; end
      ss_prev = ss_o; sck_prev = sck_o;
      if (!b_ss_o) b_run++;
      else if (!b_ss_prev) begin b_ss_len = b_run; b_run = 0; end
      if (b_sck_o && !b_sck_prev) b_pulses++;
      if (b_rsp_valid != 2'b00) begin b_rsp_cnt++; b_rdata = b_rsp_rdata; b_rsp = b_rsp_valid; end
      b_ss_prev = b_ss_o; b_sck_prev = b_sck_o;
    end
  end

  task automatic request(input logic [1:0] vmask);
    int base;
    bit got;
    base = acc_cnt;
    got = 1'b0;
    req_valid = vmask;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != base) got = 1'b1;
    end
    req_valid = 2'b00;
    if (!got) check1("accept_timeout", 32'(acc_cnt), 32'(base + 1));
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(posedge clk); #1;
      if (expq.size() == 0) done = 1'b1;
    end
    if (!done) check1("done_timeout", 32'(expq.size()), 32'h0);
  endtask

  initial begin
    int p0, r0;
    int exp_seq[6];
    exp_seq = '{0, 1, 0, 1, 0, 1};
    rst = 1'b1; en = 1'b0; req_valid = '0; req_wdata = '0; req_nbits = '0; miso_mode = 1'b0;
    b_en = 1'b0; b_req_valid = '0; b_req_wdata = '0; b_req_nbits = '0; b_miso = 1'b0;
    @(posedge clk); #1 mon_on = 1'b1;
    @(negedge clk);
    check1("rst_ss", 32'(ss_o), 32'h1);
    check1("rst_sck_mosi", 32'({sck_o, mosi_o}), 32'h0);
    check1("rst_t", 32'({sck_t, mosi_t, ss_t}), 32'h7);
    check1("rst_rdata_busy", rsp_rdata | 32'(busy) | 32'(rsp_valid), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // en low: no grant, pins released
    req_valid = 2'b01;
    repeat (4) begin
      @(negedge clk);
      check1("en0_ready", 32'(req_ready), 32'h0);
      check1("en0_t", 32'({sck_t, mosi_t, ss_t}), 32'h7);
    end
    @(posedge clk); #1 req_valid = 2'b00; en = 1'b1; b_en = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single 8-bit transfer, loopback
    p0 = pulses; miso_mode = 1'b0;
    req_wdata[0] = 32'hA5; req_nbits[0] = 5'd7;
    request(2'b01); wait_done();
    check1("single_rdata", last_rdata, 32'h0000_00A5);
    check1("single_pulses", 32'(pulses - p0), 32'd8);
    check1("single_mosi", {24'h0, mosi_cap[7:0]}, 32'hA5);
    check1("single_ss_low", 32'(ss_len), 32'd34);
    check1("single_owner", 32'(last_rsp), 32'h1);

    // Full 32-bit frame, miso tied high
    p0 = pulses; miso_mode = 1'b1;
    req_wdata[1] = 32'h8000_0001; req_nbits[1] = 5'd31;
    request(2'b10); wait_done();
    check1("full_rdata", last_rdata, 32'hFFFF_FFFF);
    check1("full_mosi", mosi_cap, 32'h8000_0001);
    check1("full_pulses", 32'(pulses - p0), 32'd32);
    check1("full_ss_low", 32'(ss_len), 32'd130);
    check1("full_owner", 32'(last_rsp), 32'h2);

    // Contention: both requesters valid for six transfers
    miso_mode = 1'b0;
    req_wdata[0] = 32'h3C; req_nbits[0] = 5'd7;
    req_wdata[1] = 32'h5;  req_nbits[1] = 5'd3;
    gnt_log.delete(); r0 = rsp_cnt; p0 = acc_cnt;
    req_valid = 2'b11;
    for (int i = 0; i < 2000 && (acc_cnt - p0) < 6; i++) begin @(posedge clk); #1; end
    req_valid = 2'b00;
    wait_done();
    check1("cont_grants", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check1("cont_seq", 32'(gnt_log.size() > i ? gnt_log[i] : 99), 32'(exp_seq[i]));
    check1("cont_rsp_count", 32'(rsp_cnt - r0), 32'd6);

    // en dropped mid-shift: frame completes, then pins release
    r0 = rsp_cnt;
    req_wdata[0] = 32'h96; req_nbits[0] = 5'd7;
    request(2'b01);
    repeat (8) @(posedge clk); #1 en = 1'b0;
    wait_done();
    @(negedge clk);
    check1("endrop_rsp", 32'(rsp_cnt - r0), 32'd1);
    check1("endrop_rdata", last_rdata, 32'h96);
    check1("endrop_t", 32'({sck_t, mosi_t, ss_t}), 32'h7);
    @(posedge clk); #1 en = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Reset mid-shift aborts; next grant goes to requester 0
    r0 = rsp_cnt;
    req_wdata[0] = 32'h5A; req_nbits[0] = 5'd7;
    request(2'b01);
    repeat (10) @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check1("abort_ss", 32'(ss_o), 32'h1);
    check1("abort_sck", 32'(sck_o), 32'h0);
    check1("abort_t", 32'({sck_t, mosi_t, ss_t}), 32'h7);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check1("abort_no_rsp", 32'(rsp_cnt - r0), 32'h0);
    req_wdata[1] = 32'h11; req_nbits[1] = 5'd3;
    gnt_log.delete();
    request(2'b11); wait_done();
    check1("abort_next_grant", 32'(gnt_log.size() > 0 ? gnt_log[0] : 99), 32'h0);

    // Minimum frame on CLK_DIV=1 instance
    for (int m = 0; m < 2; m++) begin
      p0 = b_pulses; r0 = b_rsp_cnt;
      b_miso = (m == 0) ? 1'b1 : 1'b0;
      b_req_wdata[0] = 32'h1; b_req_nbits[0] = 5'd0;
      b_req_valid = 2'b01;
      @(negedge clk);
      check1("min_ready", 32'(b_req_ready), 32'h1);
      @(posedge clk); #1 b_req_valid = 2'b00;
      repeat (8) @(posedge clk); #1;
      check1("min_ss_low", 32'(b_ss_len), 32'd3);
      check1("min_pulses", 32'(b_pulses - p0), 32'd1);
      check1("min_rsp", 32'(b_rsp_cnt - r0), 32'd1);
      check1("min_rdata", b_rdata, (m == 0) ? 32'h1 : 32'h0);
      check1("min_owner", 32'(b_rsp), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
